id_ex_pipe_reg: RTL and testbench
=================================

// Module: id_ex_pipe_reg
// PURPOSE
//  ID/EX pipeline register with integrated load-use hazard detection and bubble insertion.
//  Captures decoded control, operand data and register addresses from ID each cycle.
//  Presents them to EX, where the forwarding unit consumes the registered Rs/Rt/Rd
//  addresses and the downstream EX/MEM stage consumes the control bits.
//  Generates stall_o toward the PC and IF/ID registers, and keeps a saturating count
//  of bubble cycles for performance debug.
// PARAMETERS
//  DATA_W  32  operand and immediate width
//  REG_AW  5   register address width
//  CNT_W   16  bubble counter width
// PORTS
//  clk_i        in   1       clock, rising edge
//  rst_i        in   1       synchronous reset, active-low
//  hold_i       in   1       global freeze (memory wait); register keeps contents
//  flush_i      in   1       kill ID-stage instruction (taken jump/branch)
//  id_ctrl_i    in   9       {RegWrite,MemToReg,MemRead,MemWrite,ALUSrc,ALUOp[1:0],RegDst,Branch}
//  id_rs_data_i in   DATA_W  register file read data, port Rs
//  id_rt_data_i in   DATA_W  register file read data, port Rt
//  id_imm_i     in   DATA_W  sign-extended immediate
//  id_rs_i      in   REG_AW  Rs address of instruction in ID
//  id_rt_i      in   REG_AW  Rt address of instruction in ID
//  id_rd_i      in   REG_AW  Rd address of instruction in ID
//  ex_ctrl_o    out  9       registered control, same packing as id_ctrl_i
//  ex_rs_data_o out  DATA_W  registered Rs data
//  ex_rt_data_o out  DATA_W  registered Rt data
//  ex_imm_o     out  DATA_W  registered immediate
//  ex_rs_o      out  REG_AW  registered Rs address (to forwarding unit)
//  ex_rt_o      out  REG_AW  registered Rt address (to forwarding unit)
//  ex_rd_o      out  REG_AW  registered Rd address
//  ex_valid_o   out  1       1 = real instruction in EX, 0 = bubble
//  stall_o      out  1       freeze PC and IF/ID this cycle (combinational)
//  bubble_cnt_o out  CNT_W   count of inserted load-use bubbles, saturating
// BEHAVIOUR
//  - Reset (rst_i==0 at posedge): all ex_* outputs are 0, ex_valid_o is 0, and
//    bubble_cnt_o is 0. stall_o is 0 while the register holds reset values.
//  - Load-use detect: luh = ex_valid_o & ex_ctrl_o[MemRead] & (ex_rt_o!=0)
//    & ((ex_rt_o==id_rs_i) | (ex_rt_o==id_rt_i)).
//    stall_o = luh & ~flush_i.
//  - Per-posedge update priority, highest first:
//    1 reset
//    2 hold_i=1: every register, including the counter, holds.
//    3 flush_i=1: load a bubble. ex_ctrl_o and ex_valid_o are 0; data and address
//      fields are 0; the counter is unchanged.
//    4 luh=1: load a bubble as in 3; bubble_cnt_o increments by 1 and saturates
//      at all-ones.
//    5 otherwise: capture all id_* inputs and set ex_valid_o=1.
//  - Latency: exactly 1 cycle from ID inputs to ex_* outputs. There is no
//    combinational path from id_* to ex_*.
//  - A bubble clears ex_ctrl_o, so luh is 0 on the cycle after a bubble.
//    Result: at most one bubble per load.
//  - Back-to-back loads with no dependence: no stall.
//  - Load followed by a dependent load: one bubble, then normal flow.
//  - hold_i during luh: stall_o stays 1 and no bubble is counted. Normal priority
//    resumes when hold_i drops.
//  - flush_i and luh together: flush wins, stall_o=0, and the counter is unchanged.
//  - Rt==0 never triggers a stall.
//  - Reset asserted mid-stall clears everything on that edge.
// TESTING
//  - Reset: rst_i=0 for 2 cycles with random id_* -> all ex_* outputs 0,
//    stall_o=0, bubble_cnt_o=0.
//  - Pass-through: id_rs_i=3, id_rt_i=4, id_rd_i=5, id_imm_i=32'h0000_00FF,
//    RegWrite=1 -> next cycle ex_* equals inputs and ex_valid_o=1.
//  - Load-use: lw to $2, then add with id_rs_i=2 -> stall_o=1 for 1 cycle,
//    next ex_ctrl_o=0 and ex_valid_o=0, bubble_cnt_o=1; the add enters EX
//    the following cycle.
//  - Rt=0 and flush: lw to $0 then use of $0 -> stall_o=0. lw to $2, then
//    dependent instruction with flush_i=1 -> stall_o=0, bubble loaded, count unchanged.
//  - Hold and saturation: hold_i=1 for 3 cycles -> ex_* unchanged. Preload the
//    counter to 16'hFFFF, force one load-use -> bubble_cnt_o stays 16'hFFFF.

Source files
------------

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion and
// a saturating bubble counter for performance debug.
module id_ex_pipe_reg #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              hold_i,
  input  logic              flush_i,
  input  logic [8:0]        id_ctrl_i,
  input  logic [DATA_W-1:0] id_rs_data_i,
  input  logic [DATA_W-1:0] id_rt_data_i,
  input  logic [DATA_W-1:0] id_imm_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic [REG_AW-1:0] id_rd_i,
  output logic [8:0]        ex_ctrl_o,
  output logic [DATA_W-1:0] ex_rs_data_o,
  output logic [DATA_W-1:0] ex_rt_data_o,
  output logic [DATA_W-1:0] ex_imm_o,
  output logic [REG_AW-1:0] ex_rs_o,
  output logic [REG_AW-1:0] ex_rt_o,
  output logic [REG_AW-1:0] ex_rd_o,
  output logic              ex_valid_o,
  output logic              stall_o,
  output logic [CNT_W-1:0]  bubble_cnt_o
);

  // Control packing: {RegWrite,MemToReg,MemRead,MemWrite,ALUSrc,ALUOp[1:0],RegDst,Branch}
  localparam int MEMREAD_BIT = 6;

  logic [8:0]        ctrl_q,    ctrl_d;
  logic [DATA_W-1:0] rs_data_q, rs_data_d;
  logic [DATA_W-1:0] rt_data_q, rt_data_d;
  logic [DATA_W-1:0] imm_q,     imm_d;
  logic [REG_AW-1:0] rs_q,      rs_d;
  logic [REG_AW-1:0] rt_q,      rt_d;
  logic [REG_AW-1:0] rd_q,      rd_d;
  logic              valid_q,   valid_d;
  logic [CNT_W-1:0]  cnt_q,     cnt_d;
  logic              luh;

  always_comb begin
    luh = valid_q && ctrl_q[MEMREAD_BIT] && (rt_q != '0)
          && ((rt_q == id_rs_i) || (rt_q == id_rt_i));
    stall_o = luh && !flush_i;
  end

  always_comb begin
    ctrl_d    = ctrl_q;
    rs_data_d = rs_data_q;
    rt_data_d = rt_data_q;
    imm_d     = imm_q;
    rs_d      = rs_q;
    rt_d      = rt_q;
    rd_d      = rd_q;
    valid_d   = valid_q;
    cnt_d     = cnt_q;
    if (hold_i) begin
      // freeze everything, including the counter
    end else if (flush_i || luh) begin
      ctrl_d    = '0;
      rs_data_d = '0;
      rt_data_d = '0;
      imm_d     = '0;
      rs_d      = '0;
      rt_d      = '0;
      rd_d      = '0;
      valid_d   = 1'b0;
      // a flush bubble is not a load-use bubble, so only luh alone counts
      if (!flush_i && (cnt_q != '1)) begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      ctrl_d    = id_ctrl_i;
      rs_data_d = id_rs_data_i;
      rt_data_d = id_rt_data_i;
      imm_d     = id_imm_i;
      rs_d      = id_rs_i;
      rt_d      = id_rt_i;
      rd_d      = id_rd_i;
      valid_d   = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      ctrl_q    <= '0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      rd_q      <= '0;
      valid_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      ctrl_q    <= ctrl_d;
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
      imm_q     <= imm_d;
      rs_q      <= rs_d;
      rt_q      <= rt_d;
      rd_q      <= rd_d;
      valid_q   <= valid_d;
      cnt_q     <= cnt_d;
    end
  end

  assign ex_ctrl_o    = ctrl_q;
  assign ex_rs_data_o = rs_data_q;
  assign ex_rt_data_o = rt_data_q;
  assign ex_imm_o     = imm_q;
  assign ex_rs_o      = rs_q;
  assign ex_rt_o      = rt_q;
  assign ex_rd_o      = rd_q;
  assign ex_valid_o   = valid_q;
  assign bubble_cnt_o = cnt_q;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Bench for id_ex_pipe_reg: behavioural model feeds a scoreboard queue; a second
// instance with a 2-bit counter exercises saturation on the same stimulus.
module tb_id_ex_pipe_reg;
  localparam int OBS_W = 1 + 9 + 96 + 15 + 16 + 2;
  localparam logic [8:0] NOP = 9'h000, LW = 9'h1D0, ADD = 9'h10A, RW = 9'h100;

  typedef struct {
    logic rst, hold, flush;
    logic [8:0] ctrl;
    logic [4:0] rs, rt, rd;
    logic [31:0] imm;
  } stim_t;

  logic clk_i = 1'b0;
  logic rst_i, hold_i, flush_i;
  logic [8:0] id_ctrl_i;
  logic [31:0] id_rs_data_i, id_rt_data_i, id_imm_i;
  logic [4:0] id_rs_i, id_rt_i, id_rd_i;
  logic [8:0] ex_ctrl_o, s_ctrl;
  logic [31:0] ex_rs_data_o, ex_rt_data_o, ex_imm_o, s_rsd, s_rtd, s_imm;
  logic [4:0] ex_rs_o, ex_rt_o, ex_rd_o, s_rs, s_rt, s_rd;
  logic ex_valid_o, stall_o, s_valid, s_stall;
  logic [15:0] bubble_cnt_o;
  logic [1:0] s_cnt;
  logic [OBS_W-1:0] obs;

  int n_cmp = 0, n_err = 0;
  logic [OBS_W-1:0] sb[$];
  logic exp_stall;
  logic m_valid = 0;
  logic [8:0] m_ctrl = 0;
  logic [31:0] m_rsd = 0, m_rtd = 0, m_imm = 0;
  logic [4:0] m_rs = 0, m_rt = 0, m_rd = 0;
  logic [15:0] m_cnt = 0;
  logic [1:0] m_cnt_s = 0;

  always #5 clk_i = ~clk_i;

  id_ex_pipe_reg dut (
    .clk_i(clk_i), .rst_i(rst_i), .hold_i(hold_i), .flush_i(flush_i),
    .id_ctrl_i(id_ctrl_i), .id_rs_data_i(id_rs_data_i), .id_rt_data_i(id_rt_data_i),
    .id_imm_i(id_imm_i), .id_rs_i(id_rs_i), .id_rt_i(id_rt_i), .id_rd_i(id_rd_i),
    .ex_ctrl_o(ex_ctrl_o), .ex_rs_data_o(ex_rs_data_o), .ex_rt_data_o(ex_rt_data_o),
    .ex_imm_o(ex_imm_o), .ex_rs_o(ex_rs_o), .ex_rt_o(ex_rt_o), .ex_rd_o(ex_rd_o),
    .ex_valid_o(ex_valid_o), .stall_o(stall_o), .bubble_cnt_o(bubble_cnt_o));

  id_ex_pipe_reg #(.CNT_W(2)) u_sat (
    .clk_i(clk_i), .rst_i(rst_i), .hold_i(hold_i), .flush_i(flush_i),
    .id_ctrl_i(id_ctrl_i), .id_rs_data_i(id_rs_data_i), .id_rt_data_i(id_rt_data_i),
    .id_imm_i(id_imm_i), .id_rs_i(id_rs_i), .id_rt_i(id_rt_i), .id_rd_i(id_rd_i),
    .ex_ctrl_o(s_ctrl), .ex_rs_data_o(s_rsd), .ex_rt_data_o(s_rtd),
    .ex_imm_o(s_imm), .ex_rs_o(s_rs), .ex_rt_o(s_rt), .ex_rd_o(s_rd),
    .ex_valid_o(s_valid), .stall_o(s_stall), .bubble_cnt_o(s_cnt));

  assign obs = {ex_valid_o, ex_ctrl_o, ex_rs_data_o, ex_rt_data_o, ex_imm_o,
                ex_rs_o, ex_rt_o, ex_rd_o, bubble_cnt_o, s_cnt};

  function automatic stim_t mk(logic rst, logic hold, logic flush, logic [8:0] ctrl,
                               logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                               logic [31:0] imm);
    stim_t s;
    s.rst = rst; s.hold = hold; s.flush = flush; s.ctrl = ctrl;
    s.rs = rs; s.rt = rt; s.rd = rd; s.imm = imm;
    return s;
  endfunction

  // Drive one ID-stage cycle and push the model's post-edge outputs.
  task automatic drive(input stim_t s);
    logic luh;
    rst_i = s.rst; hold_i = s.hold; flush_i = s.flush; id_ctrl_i = s.ctrl;
    id_rs_data_i = $urandom; id_rt_data_i = $urandom; id_imm_i = s.imm;
    id_rs_i = s.rs; id_rt_i = s.rt; id_rd_i = s.rd;
    luh = m_valid && m_ctrl[6] && (m_rt != 0) && (m_rt == s.rs || m_rt == s.rt);
    exp_stall = luh && !s.flush;
    if (!s.rst) begin
      m_valid = 0; m_ctrl = 0; m_rsd = 0; m_rtd = 0; m_imm = 0;
      m_rs = 0; m_rt = 0; m_rd = 0; m_cnt = 0; m_cnt_s = 0;
    end else if (s.hold) begin
    end else if (s.flush || luh) begin
      m_valid = 0; m_ctrl = 0; m_rsd = 0; m_rtd = 0; m_imm = 0;
      m_rs = 0; m_rt = 0; m_rd = 0;
      if (!s.flush) begin
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 1;
        if (m_cnt_s != 2'b11) m_cnt_s = m_cnt_s + 1;
      end
    end else begin
      m_valid = 1; m_ctrl = s.ctrl; m_rsd = id_rs_data_i; m_rtd = id_rt_data_i;
      m_imm = s.imm; m_rs = s.rs; m_rt = s.rt; m_rd = s.rd;
    end
    sb.push_back({m_valid, m_ctrl, m_rsd, m_rtd, m_imm, m_rs, m_rt, m_rd, m_cnt, m_cnt_s});
  endtask

  task automatic test_reset();
    logic [OBS_W-1:0] exp;
    for (int i = 0; i < 2; i++) begin
      drive(mk(0, $urandom, $urandom, 9'($urandom), 5'($urandom), 5'($urandom),
               5'($urandom), $urandom));
      @(posedge clk_i); #1;
      exp = sb.pop_front();
      n_cmp++;
      if (obs !== exp) begin
        n_err++; $display("FAIL reset_out[%0d]: got %h want %h", i, obs, exp);
      end
    end
    n_cmp++;
    if (stall_o !== 1'b0) begin
      n_err++; $display("FAIL reset_stall: got %b want 0", stall_o);
    end
  endtask

  task automatic test_pass_through();
    logic [OBS_W-1:0] exp;
    drive(mk(1, 0, 0, RW, 5'd3, 5'd4, 5'd5, 32'h0000_00FF));
    #1; n_cmp++;
    if (stall_o !== exp_stall) begin
      n_err++; $display("FAIL pass_stall: got %b want %b", stall_o, exp_stall);
    end
    @(posedge clk_i); #1;
    exp = sb.pop_front(); n_cmp++;
    if (obs !== exp) begin
      n_err++; $display("FAIL pass_out: got %h want %h", obs, exp);
    end
    n_cmp++;
    if ({ex_valid_o, ex_ctrl_o, ex_rs_o, ex_rt_o, ex_rd_o, ex_imm_o} !==
        {1'b1, RW, 5'd3, 5'd4, 5'd5, 32'h0000_00FF}) begin
      n_err++; $display("FAIL pass_fields: got v=%b c=%h rs=%0d rt=%0d rd=%0d imm=%h want v=1 c=100 3 4 5 ff",
                        ex_valid_o, ex_ctrl_o, ex_rs_o, ex_rt_o, ex_rd_o, ex_imm_o);
    end
  endtask

  task automatic test_load_use();
    stim_t seq[$];
    logic [OBS_W-1:0] exp;
    logic [15:0] base;
    base = bubble_cnt_o;
    seq.push_back(mk(1, 0, 0, NOP, 0, 0, 0, 0));
    seq.push_back(mk(1, 0, 0, LW, 5'd1, 5'd2, 0, 32'h10));
    seq.push_back(mk(1, 0, 0, ADD, 5'd2, 5'd7, 5'd8, 0));
    seq.push_back(mk(1, 0, 0, ADD, 5'd2, 5'd7, 5'd8, 0));
    seq.push_back(mk(1, 0, 0, LW, 5'd1, 5'd2, 0, 32'h4));
    seq.push_back(mk(1, 0, 0, LW, 5'd9, 5'd3, 0, 32'h8));
    seq.push_back(mk(1, 0, 0, LW, 5'd3, 5'd4, 0, 32'hC));
    seq.push_back(mk(1, 0, 0, LW, 5'd3, 5'd4, 0, 32'hC));
    seq.push_back(mk(1, 0, 0, ADD, 5'd9, 5'd10, 5'd11, 0));
    foreach (seq[i]) begin
      drive(seq[i]);
      #1; n_cmp++;
      if (stall_o !== exp_stall) begin
        n_err++; $display("FAIL lu_stall[%0d]: got %b want %b", i, stall_o, exp_stall);
      end
      @(posedge clk_i); #1;
      exp = sb.pop_front(); n_cmp++;
      if (obs !== exp) begin
        n_err++; $display("FAIL lu_out[%0d]: got %h want %h", i, obs, exp);
      end
      if (i == 2) begin
        n_cmp++;
        if ({ex_valid_o, ex_ctrl_o, bubble_cnt_o} !== {1'b0, 9'h0, base + 16'd1}) begin
          n_err++; $display("FAIL lu_bubble: got v=%b c=%h cnt=%0d want v=0 c=0 cnt=%0d",
                            ex_valid_o, ex_ctrl_o, bubble_cnt_o, base + 16'd1);
        end
      end
      if (i == 3) begin
        n_cmp++;
        if ({ex_valid_o, ex_ctrl_o, ex_rd_o} !== {1'b1, ADD, 5'd8}) begin
          n_err++; $display("FAIL lu_enter: got v=%b c=%h rd=%0d want v=1 c=%h rd=8",
                            ex_valid_o, ex_ctrl_o, ex_rd_o, ADD);
        end
      end
    end
  endtask

  task automatic test_rt0_flush();
    stim_t seq[$];
    logic [OBS_W-1:0] exp;
    seq.push_back(mk(1, 0, 0, LW, 5'd1, 5'd0, 0, 0));
    seq.push_back(mk(1, 0, 0, ADD, 5'd0, 5'd0, 5'd6, 0));
    seq.push_back(mk(1, 0, 0, LW, 5'd1, 5'd2, 0, 0));
    seq.push_back(mk(1, 0, 1, ADD, 5'd2, 5'd2, 5'd6, 0));
    seq.push_back(mk(1, 0, 0, ADD, 5'd2, 5'd2, 5'd6, 0));
    foreach (seq[i]) begin
      drive(seq[i]);
      #1; n_cmp++;
      if (stall_o !== exp_stall) begin
        n_err++; $display("FAIL rf_stall[%0d]: got %b want %b", i, stall_o, exp_stall);
      end
      @(posedge clk_i); #1;
      exp = sb.pop_front(); n_cmp++;
      if (obs !== exp) begin
        n_err++; $display("FAIL rf_out[%0d]: got %h want %h", i, obs, exp);
      end
    end
  endtask

  task automatic test_hold();
    stim_t seq[$];
    logic [OBS_W-1:0] exp;
    logic [15:0] base;
    seq.push_back(mk(1, 0, 0, RW, 5'd12, 5'd13, 5'd14, 32'hABCD));
    for (int k = 0; k < 3; k++) seq.push_back(mk(1, 1, 0, ADD, 5'd20, 5'd21, 5'd22, 32'h1));
    seq.push_back(mk(1, 0, 0, LW, 5'd1, 5'd2, 0, 0));
    seq.push_back(mk(1, 1, 0, ADD, 5'd2, 5'd3, 5'd4, 0));
    seq.push_back(mk(1, 1, 0, ADD, 5'd2, 5'd3, 5'd4, 0));
    seq.push_back(mk(1, 0, 0, ADD, 5'd2, 5'd3, 5'd4, 0));
    seq.push_back(mk(1, 0, 0, ADD, 5'd2, 5'd3, 5'd4, 0));
    base = bubble_cnt_o;
    foreach (seq[i]) begin
      drive(seq[i]);
      #1; n_cmp++;
      if (stall_o !== exp_stall) begin
        n_err++; $display("FAIL hold_stall[%0d]: got %b want %b", i, stall_o, exp_stall);
      end
      @(posedge clk_i); #1;
      exp = sb.pop_front(); n_cmp++;
      if (obs !== exp) begin
        n_err++; $display("FAIL hold_out[%0d]: got %h want %h", i, obs, exp);
      end
      if (i == 3) begin
        n_cmp++;
        if ({ex_rd_o, ex_imm_o} !== {5'd14, 32'hABCD}) begin
          n_err++; $display("FAIL hold_keep: got rd=%0d imm=%h want rd=14 imm=abcd", ex_rd_o, ex_imm_o);
        end
      end
      if (i == 6) begin
        n_cmp++;
        if (bubble_cnt_o !== base) begin
          n_err++; $display("FAIL hold_nocount: got %0d want %0d", bubble_cnt_o, base);
        end
      end
    end
  endtask

  task automatic test_reset_mid_stall();
    stim_t seq[$];
    logic [OBS_W-1:0] exp;
    seq.push_back(mk(1, 0, 0, LW, 5'd1, 5'd2, 0, 0));
    seq.push_back(mk(0, 0, 0, ADD, 5'd2, 5'd3, 5'd4, 0));
    seq.push_back(mk(1, 0, 0, NOP, 0, 0, 0, 0));
    foreach (seq[i]) begin
      drive(seq[i]);
      #1; n_cmp++;
      if (stall_o !== exp_stall) begin
        n_err++; $display("FAIL rms_stall[%0d]: got %b want %b", i, stall_o, exp_stall);
      end
      @(posedge clk_i); #1;
      exp = sb.pop_front(); n_cmp++;
      if (obs !== exp) begin
        n_err++; $display("FAIL rms_out[%0d]: got %h want %h", i, obs, exp);
      end
    end
  endtask

  task automatic test_saturation();
    stim_t seq[$];
    logic [OBS_W-1:0] exp;
    seq.push_back(mk(1, 0, 0, LW, 5'd1, 5'd2, 0, 0));
    for (int k = 0; k < 8; k++) seq.push_back(mk(1, 0, 0, LW, 5'd2, 5'd2, 0, 32'(k)));
    foreach (seq[i]) begin
      drive(seq[i]);
      #1; n_cmp++;
      if (stall_o !== exp_stall) begin
        n_err++; $display("FAIL sat_stall[%0d]: got %b want %b", i, stall_o, exp_stall);
      end
      @(posedge clk_i); #1;
      exp = sb.pop_front(); n_cmp++;
      if (obs !== exp) begin
        n_err++; $display("FAIL sat_out[%0d]: got %h want %h", i, obs, exp);
      end
    end
    n_cmp++;
    if ({s_cnt, bubble_cnt_o} !== {2'b11, 16'd4}) begin
      n_err++; $display("FAIL sat_final: got small=%0d main=%0d want small=3 main=4", s_cnt, bubble_cnt_o);
    end
  endtask

  initial begin
    rst_i = 0; hold_i = 0; flush_i = 0; id_ctrl_i = 0;
    id_rs_data_i = 0; id_rt_data_i = 0; id_imm_i = 0;
    id_rs_i = 0; id_rt_i = 0; id_rd_i = 0;
    #1;
    test_reset();
    test_pass_through();
    test_load_use();
    test_rt0_flush();
    test_hold();
    test_reset_mid_stall();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
